alarm_ctrl: RTL and testbench



---
 rtl/alarm_pkg.sv | 23 ++
 rtl/time_add_min.sv | 29 ++
 rtl/alarm_ctrl.sv | 141 ++++++++++++++
 tb/tb_alarm_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm controller: FSM state encoding,
// 24-hour time field limits and a helper that validates a {hrs, mins} word.
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } alarm_state_t;

    localparam int MAX_MIN = 59;
    localparam int MAX_HR  = 23;
    localparam int HR_W    = 8;
    localparam int MIN_W   = 8;
    localparam int TIME_W  = HR_W + MIN_W;

    // True when the time word holds a legal 24-hour clock value.
    function automatic logic timeValid(input logic [TIME_W-1:0] t);
        return (t[TIME_W-1:MIN_W] <= HR_W'(MAX_HR)) &&
               (t[MIN_W-1:0] <= MIN_W'(MAX_MIN));
    endfunction

endpackage

// File: rtl/time_add_min.sv
// Combinational adder of a fixed number of minutes to a {hrs, mins} word.
// Minutes wrap at 60 with a carry into hours, hours wrap at 24.
module time_add_min
    import alarm_pkg::*;
#(
    parameter int N = 5
) (
    input  logic [TIME_W-1:0] timeIn,
    output logic [TIME_W-1:0] timeOut
);

    logic [MIN_W-1:0] minSum;
    logic [HR_W-1:0]  hrSum;

    // Add N minutes, fold overflow into the hour, then wrap the hour past midnight.
    always_comb begin
        minSum = timeIn[MIN_W-1:0] + MIN_W'(N);
        hrSum  = timeIn[TIME_W-1:MIN_W];
        if (minSum > MIN_W'(MAX_MIN)) begin
            minSum = minSum - MIN_W'(MAX_MIN + 1);
            hrSum  = hrSum + HR_W'(1);
        end
        if (hrSum > HR_W'(MAX_HR)) begin
            hrSum = hrSum - HR_W'(MAX_HR + 1);
        end
        timeOut = {hrSum, minSum};
    end

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm controller: compares the running 24-hour time against a stored alarm,
// rings a pulsed buzzer, and handles snooze (limited count), stop and a
// ring timeout counted in seconds.
module alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int SNOOZE_MIN     = 5,
    parameter int MAX_SNOOZE     = 3,
    parameter int RING_TIMEOUT_S = 60
) (
    input  logic              clk,
    input  logic              RESET_n,
    input  logic [TIME_W-1:0] time_24,
    input  logic              sec_tick,
    input  logic              alarm_en,
    input  logic              alarm_set,
    input  logic [TIME_W-1:0] alarm_in,
    input  logic              snooze_btn,
    input  logic              stop_btn,
    output logic [TIME_W-1:0] alarm_time,
    output logic              ringing,
    output logic              snoozing,
    output logic              buzzer
);

    localparam int CNT_W = (MAX_SNOOZE < 3) ? 2 : $clog2(MAX_SNOOZE + 1);

    alarm_state_t      state;
    alarm_state_t      stateNext;
    logic [TIME_W-1:0] alarmReg;
    logic [TIME_W-1:0] targetReg;
    logic [TIME_W-1:0] snoozeTarget;
    logic [CNT_W-1:0]  snoozeCnt;
    logic [6:0]        secCnt;
    logic              beep;
    logic              armed;
    logic              snoozeQ;
    logic              stopQ;
    logic              snoozeEdge;
    logic              stopEdge;
    logic              loadValid;
    logic              snoozeAllowed;
    logic              timeoutHit;
    logic              leavingToIdle;

    assign snoozeEdge    = snooze_btn & ~snoozeQ;
    assign stopEdge      = stop_btn & ~stopQ;
    assign loadValid     = alarm_set && timeValid(alarm_in);
    assign snoozeAllowed = int'(snoozeCnt) < MAX_SNOOZE;
    assign timeoutHit    = sec_tick && (secCnt == 7'(RING_TIMEOUT_S - 1));
    assign leavingToIdle = (state != IDLE) && (stateNext == IDLE);

    time_add_min #(.N(SNOOZE_MIN)) uSnoozeAdd (
        .timeIn  (time_24),
        .timeOut (snoozeTarget)
    );

    // Next-state decision; setting/disarming beats stop, stop beats snooze,
    // snooze beats timeout, and matching is lowest.
    always_comb begin
        stateNext = state;
        if (alarm_set || !alarm_en) begin
            stateNext = IDLE;
        end else if (stopEdge) begin
            stateNext = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (armed && (time_24 == targetReg)) stateNext = RING;
                end
                RING: begin
                    if (snoozeEdge)      stateNext = snoozeAllowed ? SNOOZE : IDLE;
                    else if (timeoutHit) stateNext = IDLE;
                end
                SNOOZE: begin
                    if (time_24 == targetReg) stateNext = RING;
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) state <= IDLE;
        else          state <= stateNext;
    end

    // Previous-sample flops so a held button yields a single event.
    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
            snoozeQ <= 1'b0;
            stopQ   <= 1'b0;
        end else begin
            snoozeQ <= snooze_btn;
            stopQ   <= stop_btn;
        end
    end

    // Stored alarm and the arm flag; arming waits until the clock has moved off
    // the alarm minute so a stop or fresh load cannot retrigger in that minute.
    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
            alarmReg <= '0;
            armed    <= 1'b0;
        end else begin
            if (loadValid) alarmReg <= alarm_in;
            if (loadValid || leavingToIdle) armed <= 1'b0;
            else if (time_24 != alarmReg)   armed <= 1'b1;
        end
    end

    // Compare target, snooze count, ring-second counter and beep phase.
    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
            targetReg <= '0;
            snoozeCnt <= '0;
            secCnt    <= '0;
            beep      <= 1'b0;
        end else if (stateNext == IDLE) begin
            targetReg <= alarmReg;
            snoozeCnt <= '0;
            secCnt    <= '0;
        end else if ((state == RING) && (stateNext == SNOOZE)) begin
            targetReg <= snoozeTarget;
            snoozeCnt <= snoozeCnt + CNT_W'(1);
        end else if ((state != RING) && (stateNext == RING)) begin
            secCnt <= '0;
            beep   <= 1'b1;
        end else if ((state == RING) && sec_tick) begin
            secCnt <= secCnt + 7'd1;
            beep   <= ~beep;
        end
    end

    assign alarm_time = alarmReg;
    assign ringing    = (state == RING);
    assign snoozing   = (state == SNOOZE);
    assign buzzer     = beep && (state == RING);

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed self-checking bench for alarm_ctrl. Expected output vectors
// {alarm_time, ringing, snoozing, buzzer} are queued before each step and
// popped for comparison once the DUT has clocked.
module tb_alarm_ctrl;

    typedef struct {
        string       tag;
        logic [18:0] exp;
    } expItem_t;

    logic        clk;
    logic        RESET_n;
    logic [15:0] time_24;
    logic        sec_tick;
    logic        alarm_en;
    logic        alarm_set;
    logic [15:0] alarm_in;
    logic        snooze_btn;
    logic        stop_btn;
    logic [15:0] alarm_time;
    logic        ringing;
    logic        snoozing;
    logic        buzzer;

    expItem_t sbQ[$];
    int       nCompared;
    int       nFailed;

    localparam logic [15:0] A0730 = 16'h071E;
    localparam logic [15:0] A2358 = 16'h173A;

    alarm_ctrl dut (
        .clk        (clk),
        .RESET_n    (RESET_n),
        .time_24    (time_24),
        .sec_tick   (sec_tick),
        .alarm_en   (alarm_en),
        .alarm_set  (alarm_set),
        .alarm_in   (alarm_in),
        .snooze_btn (snooze_btn),
        .stop_btn   (stop_btn),
        .alarm_time (alarm_time),
        .ringing    (ringing),
        .snoozing   (snoozing),
        .buzzer     (buzzer)
    );

    // Free-running 100 MHz-style clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Queue the expected outputs for the next comparison.
    task automatic expectOut(input string tag, input logic [15:0] at,
                             input logic r, input logic s, input logic b);
        expItem_t e;
        e.tag = tag;
        e.exp = {at, r, s, b};
        sbQ.push_back(e);
    endtask

    // Advance n clock edges; inputs change and outputs are sampled 1 time unit after each edge.
    task automatic applyStimulus(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Pop the oldest expectation and compare it with the DUT outputs.
    task automatic checkOutput();
        expItem_t    e;
        logic [18:0] obs;
        nCompared++;
        if (sbQ.size() == 0) begin
            nFailed++;
            $display("[TB] FAIL scoreboard-empty: observed output with no expected value queued");
            return;
        end
        e   = sbQ.pop_front();
        obs = {alarm_time, ringing, snoozing, buzzer};
        assert (obs === e.exp) else begin
            nFailed++;
            $error("[TB] FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
        end
    endtask

    // One clocked step with its expectation.
    task automatic step(input string tag, input logic [15:0] at,
                        input logic r, input logic s, input logic b);
        expectOut(tag, at, r, s, b);
        applyStimulus(1);
        checkOutput();
    endtask

    initial begin
        nCompared  = 0;
        nFailed    = 0;
        RESET_n    = 1'b0;
        time_24    = 16'h0700;
        sec_tick   = 1'b0;
        alarm_en   = 1'b0;
        alarm_set  = 1'b0;
        alarm_in   = 16'h0000;
        snooze_btn = 1'b0;
        stop_btn   = 1'b0;

        #2;
        expectOut("reset state", 16'h0000, 1'b0, 1'b0, 1'b0);
        checkOutput();
        applyStimulus(2);
        RESET_n = 1'b1;
        $display("[TB] reset released");

        alarm_in  = A0730;
        alarm_set = 1'b1;
        step("load 07:30", A0730, 1'b0, 1'b0, 1'b0);
        alarm_set = 1'b0;
        alarm_en  = 1'b1;
        step("arm at 07:00", A0730, 1'b0, 1'b0, 1'b0);
        time_24 = 16'h071D;
        step("idle at 07:29", A0730, 1'b0, 1'b0, 1'b0);
        time_24 = A0730;
        step("match 07:30", A0730, 1'b1, 1'b0, 1'b1);

        sec_tick = 1'b1;
        step("beep toggle 1", A0730, 1'b1, 1'b0, 1'b0);
        sec_tick = 1'b0;
        step("beep hold", A0730, 1'b1, 1'b0, 1'b0);
        sec_tick = 1'b1;
        step("beep toggle 2", A0730, 1'b1, 1'b0, 1'b1);
        sec_tick = 1'b0;

        snooze_btn = 1'b1;
        step("snooze 1", A0730, 1'b0, 1'b1, 1'b0);
        step("snooze held", A0730, 1'b0, 1'b1, 1'b0);
        snooze_btn = 1'b0;
        time_24 = 16'h0722;
        step("snooze wait 07:34", A0730, 1'b0, 1'b1, 1'b0);
        time_24 = 16'h0723;
        step("re-ring 07:35", A0730, 1'b1, 1'b0, 1'b1);

        snooze_btn = 1'b1;
        step("snooze 2", A0730, 1'b0, 1'b1, 1'b0);
        snooze_btn = 1'b0;
        time_24 = 16'h0728;
        step("re-ring 07:40", A0730, 1'b1, 1'b0, 1'b1);
        snooze_btn = 1'b1;
        step("snooze 3", A0730, 1'b0, 1'b1, 1'b0);
        snooze_btn = 1'b0;
        time_24 = 16'h072D;
        step("re-ring 07:45", A0730, 1'b1, 1'b0, 1'b1);
        snooze_btn = 1'b1;
        step("snooze 4 stops", A0730, 1'b0, 1'b0, 1'b0);
        snooze_btn = 1'b0;
        step("idle after limit", A0730, 1'b0, 1'b0, 1'b0);

        time_24 = A0730;
        step("next day ring", A0730, 1'b1, 1'b0, 1'b1);
        snooze_btn = 1'b1;
        step("snooze count reset", A0730, 1'b0, 1'b1, 1'b0);
        snooze_btn = 1'b0;
        time_24 = 16'h0723;
        step("ring after snooze", A0730, 1'b1, 1'b0, 1'b1);
        stop_btn = 1'b1;
        step("stop from ring", A0730, 1'b0, 1'b0, 1'b0);
        stop_btn = 1'b0;

        time_24 = 16'h071D;
        step("idle 07:29 again", A0730, 1'b0, 1'b0, 1'b0);
        time_24 = A0730;
        step("ring 07:30 again", A0730, 1'b1, 1'b0, 1'b1);
        stop_btn = 1'b1;
        step("stop at 07:30", A0730, 1'b0, 1'b0, 1'b0);
        stop_btn = 1'b0;
        step("no retrigger 1", A0730, 1'b0, 1'b0, 1'b0);
        step("no retrigger 2", A0730, 1'b0, 1'b0, 1'b0);
        time_24 = 16'h071F;
        step("idle 07:31", A0730, 1'b0, 1'b0, 1'b0);
        time_24 = A0730;
        step("fires next day", A0730, 1'b1, 1'b0, 1'b1);

        for (int i = 0; i < 59; i++) begin
            sec_tick = 1'b1;
            applyStimulus(1);
            sec_tick = 1'b0;
            applyStimulus(1);
        end
        expectOut("59 ticks still ringing", A0730, 1'b1, 1'b0, 1'b0);
        checkOutput();
        sec_tick = 1'b1;
        step("timeout on 60th tick", A0730, 1'b0, 1'b0, 1'b0);
        sec_tick = 1'b0;

        alarm_in  = A2358;
        alarm_set = 1'b1;
        step("load 23:58", A2358, 1'b0, 1'b0, 1'b0);
        alarm_set = 1'b0;
        time_24 = 16'h1739;
        step("idle 23:57", A2358, 1'b0, 1'b0, 1'b0);
        time_24 = A2358;
        step("ring 23:58", A2358, 1'b1, 1'b0, 1'b1);
        snooze_btn = 1'b1;
        step("snooze at 23:58", A2358, 1'b0, 1'b1, 1'b0);
        snooze_btn = 1'b0;
        time_24 = 16'h0002;
        step("snooze wait 00:02", A2358, 1'b0, 1'b1, 1'b0);
        time_24 = 16'h0003;
        step("wrap target 00:03", A2358, 1'b1, 1'b0, 1'b1);

        alarm_in  = 16'h180A;
        alarm_set = 1'b1;
        step("reject 24:10", A2358, 1'b0, 1'b0, 1'b0);
        alarm_in = 16'h073C;
        step("reject 07:60", A2358, 1'b0, 1'b0, 1'b0);
        alarm_set = 1'b0;

        time_24 = 16'h1739;
        step("idle before reset", A2358, 1'b0, 1'b0, 1'b0);
        time_24 = A2358;
        step("ring before reset", A2358, 1'b1, 1'b0, 1'b1);
        #2;
        RESET_n = 1'b0;
        #1;
        expectOut("async reset mid-ring", 16'h0000, 1'b0, 1'b0, 1'b0);
        checkOutput();
        applyStimulus(1);
        RESET_n = 1'b1;
        step("after reset", 16'h0000, 1'b0, 1'b0, 1'b0);

        alarm_in  = A0730;
        alarm_set = 1'b1;
        time_24   = 16'h0700;
        step("reload 07:30", A0730, 1'b0, 1'b0, 1'b0);
        alarm_set = 1'b0;
        step("re-arm", A0730, 1'b0, 1'b0, 1'b0);
        time_24 = A0730;
        step("ring for combo", A0730, 1'b1, 1'b0, 1'b1);
        snooze_btn = 1'b1;
        stop_btn   = 1'b1;
        step("stop+snooze together", A0730, 1'b0, 1'b0, 1'b0);
        snooze_btn = 1'b0;
        stop_btn   = 1'b0;
        step("idle after combo", A0730, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
        $finish;
    end

endmodule
